mod_n_updown_counter: RTL
=========================

# mod_n_updown_counter

Parametrised modulo-N up/down counter: the general-purpose successor to the fixed MOD-6 counter, for any modulus, with count enable, direction control, synchronous clear and parallel load, wrap or saturate mode, and cascade outputs. It serves as a standalone divider/sequencer or as one stage of a multi-digit chain (e.g. MODULUS=10 for BCD digits, 6 for the tens-of-seconds digit) on a single clock domain.

## Interface
- MODULUS, 6, number of states; count sequence is 0..MODULUS-1; legal range 2..2^WIDTH.
- WIDTH, 3, bit width of count and load_val; must satisfy 2^WIDTH >= MODULUS.
- clk  input  1  clock; all state updates on the falling edge of clk.
- reset  input  1  synchronous, active-low reset, sampled on the falling edge of clk.
- clr  input  1  synchronous clear to 0, active-high.
- load  input  1  parallel load strobe, active-high.
- load_val  input  WIDTH  value loaded when load=1.
- en  input  1  count enable, active-high.
- up_dn  input  1  1 = count up, 0 = count down.
- sat  input  1  1 = saturate at the end of the range, 0 = wrap modulo MODULUS.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (up_dn ? count==MODULUS-1 : count==0); use as the next stage's en.
- wrap  output  1  registered one-cycle pulse; high for the cycle after a wrap transition.
- load_err  output  1  registered one-cycle pulse; high for the cycle after a load with load_val >= MODULUS.

## Operation
- Priority per falling edge of clk, highest first:
  - reset=0: count=0, wrap=0, load_err=0.
  - clr=1: count=0, wrap=0, load_err=0.
  - load=1: count=load_val if load_val < MODULUS, else count=MODULUS-1 and load_err=1; wrap=0.
  - en=1, up_dn=1: count<MODULUS-1 gives count+1. At MODULUS-1, sat=0 gives count=0 and wrap=1; sat=1 holds MODULUS-1.
  - en=1, up_dn=0: count>0 gives count-1. At 0, sat=0 gives count=MODULUS-1 and wrap=1; sat=1 holds 0.
  - otherwise: count holds; wrap=0, load_err=0.
- wrap and load_err are never high on two consecutive cycles unless the triggering event repeats on consecutive cycles.
- Saturate hold at the limit does not assert wrap. tc still asserts at the limit, so a cascaded stage advances every enabled cycle while this stage is saturated. This is intended; drive sat=0 in cascades.
- Illegal count values (count >= MODULUS, reachable only through X/upset): the next enabled step or any load/clr returns count to the legal range. Up from an illegal value goes to 0; down goes to MODULUS-1. wrap is not asserted.
- Arithmetic is WIDTH bits wide with no overflow. Compare against MODULUS-1 before incrementing, so MODULUS=2^WIDTH wraps correctly.
- Direction change takes effect on the same edge; there is no pipeline.

## Timing
- count updates one falling edge after the inputs are sampled; latency is 1 cycle.
- tc is combinational from count, en and up_dn; it is valid the same cycle, with no register.
- wrap and load_err are valid for the one full cycle after the triggering edge.
- Reset out: all outputs low. count=0; tc=0 while en=0, and tc=1 with en=1, up_dn=0.
- Reset mid-count takes effect at the next falling edge, regardless of clr, load or en.
- Simultaneous clr and load: clr wins. Simultaneous load and en: load wins and no count step occurs.

## Test plan
- Reset/hold: reset=0 for 2 edges, then reset=1, en=0 for 5 edges -> count=0, wrap=0, load_err=0 throughout.
- Up wrap (MODULUS=6, sat=0, up_dn=1, en=1): 13 edges -> count 1,2,3,4,5,0,1,2,3,4,5,0,1. wrap pulses for one cycle after each 5→0 transition. tc=1 exactly while count=5.
- Down and saturate: load 2, up_dn=0, sat=1, en=1 for 4 edges -> count 1,0,0,0 and wrap never set. Then sat=0 for 1 edge -> count=5 and wrap=1.
- Load range: load_val=4 -> count=4, load_err=0. load_val=7 -> count=5 and load_err=1 for one cycle. Same edge with clr=1 and load=1, load_val=3 -> count=0.
- Cascade: two instances, units MODULUS=10 and tens MODULUS=6; tens.en=units.tc, up, sat=0, 60 edges -> tens:units goes 0:0 → 5:9 → 0:0. The tens-stage wrap pulses once, after edge 60.
- Mid-operation reset: count=3 with en=1, load=1, clr=0, then reset=0 for one edge -> count=0, wrap=0, load_err=0 on that edge.

Source files
------------

// File: rtl/mod_n_updown_counter_if.sv
// mod_n_updown_counter_if: control/status bundle for one modulo-N counter stage
//   clr, load, load_val, en, up_dn, sat : controls driven by master into the counter
//   count, tc, wrap, load_err           : status driven by the counter (slave)
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 3
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output clr, load, load_val, en, up_dn, sat,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up_dn, sat,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-N up/down counter with clear, load, wrap/saturate and cascade outputs
//   clk_i    : clock, state updates on the falling edge
//   reset_ni : synchronous active-low reset
//   bus      : slave side of mod_n_updown_counter_if (controls in, count/tc/wrap/load_err out)
module mod_n_updown_counter #(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 3
) (
    input logic                          clk_i,
    input logic                          reset_ni,
    mod_n_updown_counter_if.slave        bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_zero, illegal;

    // Compare against MAX rather than incrementing first, so MODULUS = 2^WIDTH needs no extra bit.
    assign at_max  = count_q == MAX;
    assign at_zero = count_q == '0;
    assign illegal = count_q > MAX;

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d    = (bus.load_val > MAX) ? MAX : bus.load_val;
            load_err_d = bus.load_val > MAX;
        end else if (bus.en) begin
            // An out-of-range count recovers to the start of the sequence in the stepping direction.
            if (illegal) begin
                count_d = bus.up_dn ? '0 : MAX;
            end else if (bus.up_dn) begin
                count_d = at_max ? (bus.sat ? MAX : '0) : count_q + 1'b1;
                wrap_d  = at_max && !bus.sat;
            end else begin
                count_d = at_zero ? (bus.sat ? '0 : MAX) : count_q - 1'b1;
                wrap_d  = at_zero && !bus.sat;
            end
        end
    end

    always_ff @(negedge clk_i) begin
        if (!reset_ni) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // tc is unregistered so a following stage sees it on the same edge this stage rolls over.
    assign bus.tc       = bus.en && (bus.up_dn ? at_max : at_zero);
    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule
